key_scan_encoder: RTL and testbench

Parametrised successor to the piano key encoder. It converts N raw, asynchronous, bouncing key inputs into a registered note code through a run-time key-to-code map, using per-key synchronisers and debounce counters. It selects between lowest-index and last-pressed priority, and emits one press event per debounced key-down through a valid/ready slot. It sits between the board key pins and the note/tone generator.

---
 rtl/key_scan_encoder.sv | 125 ++++++++++++
 tb/tb_key_scan_encoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_encoder.sv
// key_scan_encoder: synchronises and debounces N raw key inputs, maps the
// selected held key to a code through a run-time map, and posts one press
// event per debounced key-down into a single valid/ready slot.
module key_scan_encoder #(
  parameter int unsigned N_KEYS   = 8,
  parameter int unsigned CODE_W   = 3,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned IDX_W    = $clog2(N_KEYS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_KEYS-1:0]          keys,
  input  logic [N_KEYS*CODE_W-1:0]   key_map,
  input  logic                       mode,
  output logic [CODE_W-1:0]          code,
  output logic                       held,
  output logic                       evt_valid,
  output logic [CODE_W-1:0]          evt_code,
  output logic [IDX_W-1:0]           evt_idx,
  input  logic                       evt_ready,
  output logic                       overflow
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] deb;
  logic [N_KEYS-1:0] deb_d;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [IDX_W-1:0]  last_idx;

  logic [CODE_W-1:0] map_arr [N_KEYS];
  logic [N_KEYS-1:0] rise;
  logic              any_rise;
  logic [IDX_W-1:0]  rise_idx;
  logic [IDX_W-1:0]  low_idx;
  logic [IDX_W-1:0]  sel;
  logic              held_next;
  logic [CODE_W-1:0] code_next;
  logic              evt_load;
  logic              evt_drop;

  // Lowest set bit index of a key vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest(input logic [N_KEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Two-flop synchronisers, per-key debounce counters and delayed debounce level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < int'(N_KEYS); i++) cnt[i] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Unpack the flat key map into one code per key.
  always_comb begin
    for (int i = 0; i < int'(N_KEYS); i++) begin
      map_arr[i] = key_map[i*CODE_W +: CODE_W];
    end
  end

  // Rise detection, priority selection and event-slot decisions.
  always_comb begin
    rise      = deb & ~deb_d;
    any_rise  = |rise;
    rise_idx  = lowest(rise);
    low_idx   = lowest(deb);
    sel       = (mode && deb[last_idx]) ? last_idx : low_idx;
    held_next = |deb;
    code_next = held_next ? map_arr[sel] : '0;
    evt_load  = any_rise && (!evt_valid || evt_ready);
    evt_drop  = any_rise && evt_valid && !evt_ready;
  end

  // Registered outputs, last-pressed tracking and the single event slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code      <= '0;
      held      <= 1'b0;
      last_idx  <= '0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_idx   <= '0;
      overflow  <= 1'b0;
    end else begin
      code <= code_next;
      held <= held_next;
      if (any_rise) last_idx <= rise_idx;
      if (evt_load) begin
        evt_valid <= 1'b1;
        evt_idx   <= rise_idx;
        evt_code  <= map_arr[rise_idx];
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (evt_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Testbench for key_scan_encoder: directed scenarios plus randomized key
// bouncing, checked against a behavioural model and an event scoreboard.
module tb_key_scan_encoder;

  localparam int unsigned N_KEYS   = 8;
  localparam int unsigned CODE_W   = 3;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned IDX_W    = $clog2(N_KEYS);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N_KEYS-1:0]        keys;
  logic [N_KEYS*CODE_W-1:0] key_map;
  logic                     mode;
  logic [CODE_W-1:0]        code;
  logic                     held;
  logic                     evt_valid;
  logic [CODE_W-1:0]        evt_code;
  logic [IDX_W-1:0]         evt_idx;
  logic                     evt_ready;
  logic                     overflow;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  key_scan_encoder #(
    .N_KEYS(N_KEYS), .CODE_W(CODE_W), .DEBOUNCE(DEBOUNCE), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .key_map(key_map), .mode(mode),
    .code(code), .held(held), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_idx(evt_idx), .evt_ready(evt_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mapv(input int i);
    return int'((key_map >> (i * CODE_W)) & ((1 << CODE_W) - 1));
  endfunction

  // Behavioural model: per-key pipeline, stability counter, debounced level.
  int s1 [N_KEYS];
  int s2 [N_KEYS];
  int d  [N_KEYS];
  int dd [N_KEYS];
  int cn [N_KEYS];
  int last_key, m_code, m_held, m_ev_v, m_ev_idx, m_ev_code, m_ovf;
  int q_idx[$];
  int q_code[$];

  always @(posedge clk) begin
    int r, low, sel;
    if (!rst_n) begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        s1[i] = 0; s2[i] = 0; d[i] = 0; dd[i] = 0; cn[i] = 0;
      end
      last_key = 0; m_code = 0; m_held = 0;
      m_ev_v = 0; m_ev_idx = 0; m_ev_code = 0; m_ovf = 0;
      q_idx.delete();
      q_code.delete();
    end else begin
      r = -1;
      low = -1;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        if (d[i] == 1 && dd[i] == 0 && r < 0) r = i;
        if (d[i] == 1 && low < 0) low = i;
      end
      m_held = (low >= 0) ? 1 : 0;
      if (mode && d[last_key] == 1) sel = last_key;
      else sel = (low < 0) ? 0 : low;
      m_code = m_held ? mapv(sel) : 0;
      if (r >= 0) begin
        if (m_ev_v == 0 || evt_ready) begin
          m_ev_v = 1; m_ev_idx = r; m_ev_code = mapv(r);
          q_idx.push_back(r);
          q_code.push_back(mapv(r));
        end else begin
          m_ovf = 1;
        end
        last_key = r;
      end else if (m_ev_v == 1 && evt_ready) begin
        m_ev_v = 0;
      end
      for (int i = 0; i < int'(N_KEYS); i++) begin
        dd[i] = d[i];
        if (s2[i] == d[i]) cn[i] = 0;
        else if (cn[i] == int'(DEBOUNCE) - 1) begin d[i] = 1 - d[i]; cn[i] = 0; end
        else cn[i] = cn[i] + 1;
        s2[i] = s1[i];
        s1[i] = keys[i] ? 1 : 0;
      end
    end
  end

  // Level comparison of registered outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("code", 32'(code), 32'(m_code));
      chk("held", 32'(held), 32'(m_held));
      chk("evt_valid", 32'(evt_valid), 32'(m_ev_v));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_ev_v == 1) begin
        chk("evt_idx", 32'(evt_idx), 32'(m_ev_idx));
        chk("evt_code", 32'(evt_code), 32'(m_ev_code));
      end
    end
  end

  // Scoreboard monitor: every accepted event must match the next expected one.
  always @(posedge clk) begin
    if (started && rst_n && evt_valid && evt_ready) begin
      if (q_idx.size() == 0) begin
        chk("sb_unexpected_evt", 32'(evt_idx), 32'hFFFF_FFFF);
      end else begin
        chk("sb_idx", 32'(evt_idx), 32'(q_idx.pop_front()));
        chk("sb_code", 32'(evt_code), 32'(q_code.pop_front()));
      end
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; keys = '0; mode = 1'b0; evt_ready = 1'b0;
    for (int i = 0; i < int'(N_KEYS); i++) key_map[i*CODE_W +: CODE_W] = CODE_W'(7 - i);
    edges(2);
    started = 1'b1;
    chk("rst_code", 32'(code), 0);
    chk("rst_held", 32'(held), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk) rst_n = 1'b1;

    // Clean press of key 2: outputs appear at the seventh edge, not before.
    @(negedge clk) keys = 8'b0000_0100;
    edges(6);
    chk("press_early_held", 32'(held), 0);
    chk("press_early_valid", 32'(evt_valid), 0);
    edges(1);
    chk("press_code", 32'(code), 5);
    chk("press_held", 32'(held), 1);
    chk("press_valid", 32'(evt_valid), 1);
    chk("press_idx", 32'(evt_idx), 2);
    chk("press_evt_code", 32'(evt_code), 5);
    @(negedge clk) keys = '0;
    edges(6);
    chk("rel_early_held", 32'(held), 1);
    edges(1);
    chk("rel_held", 32'(held), 0);
    chk("rel_code", 32'(code), 0);
    chk("rel_idx_stable", 32'(evt_idx), 2);
    @(negedge clk) evt_ready = 1'b1;
    edges(1);
    chk("accept_clears", 32'(evt_valid), 0);
    @(negedge clk) evt_ready = 1'b0;

    // Bouncing key 3 produces a single event.
    for (int p = 1; p <= 3; p++) begin
      @(negedge clk) keys = 8'b0000_1000;
      repeat (p) @(negedge clk);
      keys = '0;
      @(negedge clk);
    end
    keys = 8'b0000_1000;
    edges(12);
    chk("bounce_idx", 32'(evt_idx), 3);
    @(negedge clk) evt_ready = 1'b1;
    edges(1);
    chk("bounce_single", 32'(evt_valid), 0);
    @(negedge clk) evt_ready = 1'b0; keys = '0;
    edges(10);

    // Overflow: key 4 then key 6 with the slot blocked.
    @(negedge clk) keys = 8'b0001_0000;
    edges(10);
    @(negedge clk) keys = 8'b0101_0000;
    edges(10);
    chk("ovf_idx", 32'(evt_idx), 4);
    chk("ovf_code", 32'(evt_code), 3);
    chk("ovf_flag", 32'(overflow), 1);
    @(negedge clk) evt_ready = 1'b1;
    edges(1);
    chk("ovf_accept", 32'(evt_valid), 0);
    @(negedge clk) evt_ready = 1'b0; keys = '0;
    edges(10);
    @(negedge clk) keys = 8'b1000_0000;
    edges(10);
    @(negedge clk) keys = 8'b1000_0001;
    edges(6);
    @(negedge clk) evt_ready = 1'b1;
    edges(1);
    chk("reload_valid", 32'(evt_valid), 1);
    chk("reload_idx", 32'(evt_idx), 0);
    chk("reload_code", 32'(evt_code), 7);
    @(negedge clk) evt_ready = 1'b0; keys = '0;
    edges(10);

    // Mode 1 last-pressed priority.
    @(negedge clk) mode = 1'b1; evt_ready = 1'b1; keys = 8'b0010_0000;
    edges(10);
    chk("m1_k5", 32'(code), 2);
    @(negedge clk) keys = 8'b0010_0010;
    edges(10);
    chk("m1_k1", 32'(code), 6);
    @(negedge clk) keys = 8'b0010_0000;
    edges(10);
    chk("m1_rel1", 32'(code), 2);
    @(negedge clk) keys = 8'b0010_0010;
    edges(10);
    @(negedge clk) keys = 8'b0000_0010;
    edges(10);
    chk("m1_rel5", 32'(code), 6);
    @(negedge clk) keys = '0; mode = 1'b0;
    edges(10);

    // Simultaneous rise of keys 2 and 6 after a reset.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1; keys = 8'b0100_0100;
    edges(7);
    chk("simul_valid", 32'(evt_valid), 1);
    chk("simul_idx", 32'(evt_idx), 2);
    edges(3);
    chk("simul_ovf", 32'(overflow), 0);
    @(negedge clk) keys = '0;
    edges(10);

    // Reset mid-debounce with an event pending; held keys re-press afterwards.
    @(negedge clk) evt_ready = 1'b0; keys = 8'b0000_1000;
    edges(10);
    @(negedge clk) keys = 8'b0010_1000;
    edges(3);
    @(negedge clk) rst_n = 1'b0;
    edges(1);
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_held", 32'(held), 0);
    chk("mid_rst_code", 32'(code), 0);
    chk("mid_rst_idx", 32'(evt_idx), 0);
    @(negedge clk) rst_n = 1'b1;
    edges(6);
    chk("post_rst_early", 32'(evt_valid), 0);
    edges(1);
    chk("post_rst_valid", 32'(evt_valid), 1);
    chk("post_rst_idx", 32'(evt_idx), 3);
    @(negedge clk) evt_ready = 1'b1; keys = '0;
    edges(10);

    // Randomized bouncing, back-pressure, mode and map changes, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < int'(N_KEYS); k++) begin
        if ($urandom_range(0, 11) == 0) keys[k] = ~keys[k];
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 499) == 0) key_map = N_KEYS*CODE_W'($urandom);
      rst_n = ($urandom_range(0, 899) != 0);
    end

    // Drain remaining events with a bounded wait.
    @(negedge clk) rst_n = 1'b1; keys = '0; evt_ready = 1'b1;
    edges(30);
    chk("sb_drained", 32'(q_idx.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
